// File: rtl/pipeline_wb_unit.sv
// Write-back stage for the 5-stage RISC-V pipeline. It selects the write-back source,
// aligns and extends sub-word loads, drops writes to x0 and counts retired instructions.
module pipeline_wb_unit #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_MEM,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        rf_wr_sel,
    input  logic [XLEN-1:0]   alu_result_MEM,
    input  logic [XLEN-1:0]   mem_data_MEM,
    input  logic [1:0]        mem_size_MEM,
    input  logic              mem_unsigned_MEM,
    input  logic [2:0]        addr_low_MEM,
    input  logic [XLEN-1:0]   pc_MEM,
    input  logic [REG_AW-1:0] rd_MEM,
    input  logic              reg_write_MEM,
    output logic [XLEN-1:0]   write_data_WB,
    output logic [REG_AW-1:0] rd_WB,
    output logic              reg_write_WB,
    output logic              valid_WB,
    output logic [CNT_W-1:0]  instret
);

    localparam int OFF_W = (XLEN == 64) ? 3 : 2;

    logic             accept;
    logic [OFF_W-1:0] off;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  field_mask;
    logic             field_msb;
    logic [XLEN-1:0]  load_value;
    logic [XLEN-1:0]  wb_value;

    assign accept  = valid_MEM & ~stall & ~flush;
    assign off     = addr_low_MEM[OFF_W-1:0];
    assign shifted = mem_data_MEM >> {off, 3'b000};

    // Dword on a 32-bit datapath collapses to an all-ones mask, i.e. behaves as a word.
    always_comb begin
        field_mask = '1;
        field_msb  = shifted[XLEN-1];
        case (mem_size_MEM)
            2'b00: begin
                field_mask = XLEN'(8'hFF);
                field_msb  = shifted[7];
            end
            2'b01: begin
                field_mask = XLEN'(16'hFFFF);
                field_msb  = shifted[15];
            end
            2'b10: begin
                field_mask = XLEN'(32'hFFFF_FFFF);
                field_msb  = shifted[31];
            end
            default: begin
                field_mask = '1;
                field_msb  = shifted[XLEN-1];
            end
        endcase
    end

    assign load_value = (shifted & field_mask)
                      | ((field_msb & ~mem_unsigned_MEM) ? ~field_mask : '0);

    always_comb begin
        wb_value = '0;
        case (rf_wr_sel)
            2'b00:   wb_value = '0;
            2'b01:   wb_value = pc_MEM + XLEN'(4);
            2'b10:   wb_value = alu_result_MEM;
            default: wb_value = load_value;
        endcase
    end

    // Bubbles clear only the qualifiers; data and rd hold their last retired values.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_data_WB <= '0;
            rd_WB         <= '0;
            reg_write_WB  <= 1'b0;
            valid_WB      <= 1'b0;
            instret       <= '0;
        end else begin
            valid_WB     <= accept;
            reg_write_WB <= accept & reg_write_MEM & (rd_MEM != '0);
            if (accept) begin
                write_data_WB <= wb_value;
                rd_WB         <= rd_MEM;
                instret       <= instret + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_wb_unit.sv
// Bench for pipeline_wb_unit: a 64-bit instance with a 4-bit counter and a 32-bit instance,
// both compared every cycle against a byte-level reference model.
module tb_pipeline_wb_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_mem, stall, flush, mem_uns, rw_mem;
    logic [1:0]  sel, mem_size;
    logic [2:0]  addr_low;
    logic [4:0]  rd_mem;
    logic [63:0] alu, mem_data, pc;

    logic [63:0] wd64;
    logic [4:0]  rd64;
    logic        rw64, v64;
    logic [3:0]  cnt64;
    logic [31:0] wd32;
    logic [4:0]  rd32;
    logic        rw32, v32;
    logic [63:0] cnt32;

    logic [63:0] exp_wd64, exp_wd32, exp_cnt32;
    logic [4:0]  exp_rd;
    logic        exp_rw, exp_valid;
    logic [3:0]  exp_cnt64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_wb_unit #(.XLEN(64), .REG_AW(5), .CNT_W(4)) dut64 (
        .clk(clk), .reset(reset), .valid_MEM(valid_mem), .stall(stall), .flush(flush),
        .rf_wr_sel(sel), .alu_result_MEM(alu), .mem_data_MEM(mem_data),
        .mem_size_MEM(mem_size), .mem_unsigned_MEM(mem_uns), .addr_low_MEM(addr_low),
        .pc_MEM(pc), .rd_MEM(rd_mem), .reg_write_MEM(rw_mem),
        .write_data_WB(wd64), .rd_WB(rd64), .reg_write_WB(rw64), .valid_WB(v64),
        .instret(cnt64)
    );

    pipeline_wb_unit #(.XLEN(32), .REG_AW(5), .CNT_W(64)) dut32 (
        .clk(clk), .reset(reset), .valid_MEM(valid_mem), .stall(stall), .flush(flush),
        .rf_wr_sel(sel), .alu_result_MEM(alu[31:0]), .mem_data_MEM(mem_data[31:0]),
        .mem_size_MEM(mem_size), .mem_unsigned_MEM(mem_uns), .addr_low_MEM(addr_low),
        .pc_MEM(pc[31:0]), .rd_MEM(rd_mem), .reg_write_MEM(rw_mem),
        .write_data_WB(wd32), .rd_WB(rd32), .reg_write_WB(rw32), .valid_WB(v32),
        .instret(cnt32)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Load result assembled byte by byte from the memory word.
    function automatic logic [63:0] ref_load(input int xlen, input logic [63:0] data,
                                              input logic [1:0] size, input logic uns,
                                              input logic [2:0] addr);
        int nb, off, sz;
        logic [63:0] v;
        nb  = xlen / 8;
        off = int'(addr) % nb;
        sz  = 1 << size;
        if (sz > nb) sz = nb;
        v = '0;
        for (int i = 0; i < sz; i++)
            if (off + i < nb) v[8*i +: 8] = data[8*(off+i) +: 8];
        if (!uns && v[8*sz-1])
            for (int b = 8*sz; b < xlen; b++) v[b] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] ref_wb(input int xlen);
        logic [63:0] mask;
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        case (sel)
            2'd0:    return 64'd0;
            2'd1:    return (pc + 64'd4) & mask;
            2'd2:    return alu & mask;
            default: return ref_load(xlen, mem_data, mem_size, mem_uns, addr_low);
        endcase
    endfunction

    task automatic compare_all();
        check("wd64", wd64, exp_wd64);
        check("rd64", 64'(rd64), 64'(exp_rd));
        check("rw64", 64'(rw64), 64'(exp_rw));
        check("valid64", 64'(v64), 64'(exp_valid));
        check("instret64", 64'(cnt64), 64'(exp_cnt64));
        check("wd32", 64'(wd32), exp_wd32);
        check("rd32", 64'(rd32), 64'(exp_rd));
        check("rw32", 64'(rw32), 64'(exp_rw));
        check("valid32", 64'(v32), 64'(exp_valid));
        check("instret32", cnt32, exp_cnt32);
    endtask

    task automatic cycle();
        logic acc;
        @(posedge clk);
        acc = valid_mem && !stall && !flush;
        if (reset) begin
            exp_wd64 = '0; exp_wd32 = '0; exp_rd = '0; exp_rw = 1'b0; exp_valid = 1'b0;
            exp_cnt64 = '0; exp_cnt32 = '0;
        end else begin
            exp_valid = acc;
            exp_rw    = acc && rw_mem && (rd_mem != 5'd0);
            if (acc) begin
                exp_wd64  = ref_wb(64);
                exp_wd32  = ref_wb(32);
                exp_rd    = rd_mem;
                exp_cnt64 = 4'((int'(exp_cnt64) + 1) % 16);
                exp_cnt32 = exp_cnt32 + 64'd1;
            end
        end
        #1;
        compare_all();
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [4:0] rd, input logic rw);
        valid_mem = v; sel = s; rd_mem = rd; rw_mem = rw;
        stall = 1'b0; flush = 1'b0; reset = 1'b0;
    endtask

    initial begin
        logic [3:0] saved;
        reset = 1'b1; valid_mem = 1'b0; stall = 1'b0; flush = 1'b0; mem_uns = 1'b0;
        rw_mem = 1'b0; sel = 2'd0; mem_size = 2'd0; addr_low = 3'd0; rd_mem = 5'd0;
        alu = '0; mem_data = '0; pc = '0;
        exp_wd64 = '0; exp_wd32 = '0; exp_rd = '0; exp_rw = 1'b0; exp_valid = 1'b0;
        exp_cnt64 = '0; exp_cnt32 = '0;
        cycle(); cycle();

        // Counter wrap: 17 back-to-back retires on a 4-bit counter.
        for (int i = 1; i <= 17; i++) begin
            drive(1'b1, 2'd2, 5'(i), 1'b1);
            alu = {$urandom, $urandom};
            cycle();
            check("wrap", 64'(cnt64), 64'(i % 16));
        end

        // Reset during continuous valid traffic.
        reset = 1'b1; cycle(); cycle();
        drive(1'b0, 2'd2, 5'd3, 1'b1);
        cycle();
        check("rst_wd", wd64, 64'd0);
        check("rst_valid", 64'(v64), 64'd0);
        check("rst_cnt", 64'(cnt64), 64'd0);

        drive(1'b1, 2'd1, 5'd1, 1'b1); pc = 64'h1000;
        cycle(); check("pc4", wd64, 64'h1004);
        drive(1'b1, 2'd2, 5'd2, 1'b1); alu = 64'hDEAD;
        cycle(); check("alu", wd64, 64'hDEAD);
        drive(1'b1, 2'd0, 5'd3, 1'b1);
        cycle(); check("zero", wd64, 64'd0);

        mem_data = 64'h8877_6655_4433_2211;
        drive(1'b1, 2'd3, 5'd4, 1'b1); mem_size = 2'd0; addr_low = 3'd7; mem_uns = 1'b0;
        cycle(); check("lb7", wd64, 64'hFFFF_FFFF_FFFF_FF88);
        drive(1'b1, 2'd3, 5'd5, 1'b1); mem_size = 2'd1; addr_low = 3'd2; mem_uns = 1'b1;
        cycle(); check("lhu2", wd64, 64'h4433);
        drive(1'b1, 2'd3, 5'd6, 1'b1); mem_size = 2'd2; addr_low = 3'd4; mem_uns = 1'b0;
        cycle(); check("lw4", wd64, 64'hFFFF_FFFF_8877_6655);

        saved = cnt64;
        drive(1'b1, 2'd2, 5'd0, 1'b1);
        cycle();
        check("x0_rw", 64'(rw64), 64'd0);
        check("x0_valid", 64'(v64), 64'd1);
        check("x0_cnt", 64'(cnt64), 64'(4'(saved + 4'd1)));

        saved = cnt64;
        drive(1'b1, 2'd2, 5'd9, 1'b1); alu = 64'h1234;
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1;
            cycle();
            check("stall_bubble", 64'(v64), 64'd0);
            check("stall_cnt", 64'(cnt64), 64'(saved));
        end
        stall = 1'b0;
        cycle();
        check("release_valid", 64'(v64), 64'd1);
        check("release_cnt", 64'(cnt64), 64'(4'(saved + 4'd1)));
        valid_mem = 1'b0;
        cycle();
        check("no_double", 64'(cnt64), 64'(4'(saved + 4'd1)));

        saved = cnt64;
        drive(1'b1, 2'd2, 5'd7, 1'b1); flush = 1'b1;
        cycle();
        check("flush_bubble", 64'(v64), 64'd0);
        check("flush_cnt", 64'(cnt64), 64'(saved));
        stall = 1'b1;
        cycle();
        check("flush_stall_cnt", 64'(cnt64), 64'(saved));

        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 49) == 0);
            valid_mem = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 7) == 0);
            sel       = 2'($urandom_range(0, 3));
            mem_size  = 2'($urandom_range(0, 3));
            mem_uns   = 1'($urandom_range(0, 1));
            addr_low  = 3'($urandom_range(0, 7));
            rd_mem    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            rw_mem    = 1'($urandom_range(0, 1));
            alu       = {$urandom, $urandom};
            mem_data  = {$urandom, $urandom};
            pc        = ($urandom_range(0, 9) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
            cycle();
            if (rw64 && rd64 == 5'd0) check("rw_x0", 64'(rw64), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
